// File: rtl/sha2_pkg.sv
// Shared constants, state encoding and SHA-2 bit functions for the sha2_core compression engine.
package sha2_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_UPDATE, S_DONE} state_e;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 round: {a..h} in, {a..h} out, a in the MSBs.
module sha2_round
  import sha2_pkg::*;
(
  input  logic [255:0] state_i,
  input  logic [31:0]  w_i,
  input  logic [31:0]  k_i,
  output logic [255:0] state_o
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_i;
  assign t1 = h + bsig1(e) + ch(e, f, g) + k_i + w_i;
  assign t2 = bsig0(a) + maj(a, b, c);
  assign state_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha2_core.sv
// Multi-block SHA-256/SHA-224 compression engine with UNROLL rounds per clock
// and a rolling 16-word message schedule.
module sha2_core
  import sha2_pkg::*;
#(
  parameter int MSG_SIZ   = 512,
  parameter int MSG_BLK   = 32,
  parameter int HASH_SIZE = 256,
  parameter int UNROLL    = 1
) (
  input  logic                 usr_clk,
  input  logic                 usr_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [MSG_SIZ-1:0]   i_msg,
  input  logic                 i_first,
  input  logic                 i_last,
  input  logic                 i_mode,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  output logic [HASH_SIZE-1:0] o_hash
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4) || MSG_SIZ != 512 ||
      MSG_BLK != 32 || HASH_SIZE != 256) begin : g_param_err
    $error("sha2_core: unsupported parameter set");
  end

  state_e       state_q, state_d;
  logic [5:0]   t_q;
  logic         chain_q, mode_q, last_q;
  logic [255:0] h_q, work_q, hash_q, h_sum, iv_sel;
  logic [511:0] w_q;
  logic [255:0] rnd_st [UNROLL+1];

  // Window word i lives at w_q[511-32*i -: 32]; shift out UNROLL words, append the new ones.
  function automatic logic [511:0] sched_step(input logic [511:0] win);
    logic [31:0]  x [16+UNROLL];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) x[i] = win[511-32*i -: 32];
    for (int j = 0; j < UNROLL; j++)
      x[16+j] = ssig1(x[14+j]) + x[9+j] + ssig0(x[1+j]) + x[j];
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i+UNROLL];
    return r;
  endfunction

  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

  assign rnd_st[0] = work_q;

  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    sha2_round u_round (
      .state_i (rnd_st[j]),
      .w_i     (w_q[511-32*j -: 32]),
      .k_i     (K_TAB[t_q + 6'(j)]),
      .state_o (rnd_st[j+1])
    );
  end

  assign h_sum  = add_words(h_q, work_q);
  assign iv_sel = i_mode ? IV_224 : IV_256;

  assign o_ready = (state_q == S_IDLE);
  assign o_valid = (state_q == S_DONE);
  assign o_hash  = hash_q;

  always_ff @(posedge usr_clk) begin
    if (usr_reset) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (i_valid) state_d = S_ROUND;
      S_ROUND:  if (t_q == 6'(64 - UNROLL)) state_d = S_UPDATE;
      S_UPDATE: state_d = last_q ? S_DONE : S_IDLE;
      S_DONE:   if (i_out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge usr_clk) begin
    if (usr_reset) begin
      chain_q <= 1'b0;
      mode_q  <= 1'b0;
      last_q  <= 1'b0;
      t_q     <= '0;
      h_q     <= '0;
      work_q  <= '0;
      w_q     <= '0;
      hash_q  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            w_q    <= i_msg;
            last_q <= i_last;
            t_q    <= '0;
            // A block arriving with no chain in progress always starts a new message.
            if (i_first || !chain_q) begin
              mode_q  <= i_mode;
              h_q     <= iv_sel;
              work_q  <= iv_sel;
              chain_q <= 1'b1;
            end else begin
              work_q <= h_q;
            end
          end
        end
        S_ROUND: begin
          work_q <= rnd_st[UNROLL];
          w_q    <= sched_step(w_q);
          t_q    <= t_q + 6'(UNROLL);
        end
        S_UPDATE: begin
          h_q <= h_sum;
          if (last_q) begin
            chain_q <= 1'b0;
            hash_q  <= mode_q ? {h_sum[255:32], 32'h0} : h_sum;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_core.sv
// Bench for sha2_core: three instances (UNROLL 1, 2, 4) driven in lock-step,
// known-answer table, corner-case sequences and random multi-block messages.
module tb_sha2_core;

  typedef struct {
    logic [511:0] msg;
    logic         first;
    logic         last;
    logic         mode;
    logic [255:0] exp;
  } vec_t;

  localparam logic [511:0] ABC   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO2  = 512'h1c0;

  localparam logic [255:0] D_ABC    = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ABC224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
  localparam logic [255:0] D_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [255:0] R_IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] R_IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         usr_clk, usr_reset, i_valid, i_first, i_last, i_mode, i_out_ready;
  logic [511:0] i_msg;
  logic         rdy [3];
  logic         vld [3];
  logic [255:0] hsh [3];

  int n_checks = 0;
  int n_fail   = 0;

  sha2_core #(.UNROLL(1)) u_u1 (
    .usr_clk(usr_clk), .usr_reset(usr_reset), .i_valid(i_valid), .o_ready(rdy[0]),
    .i_msg(i_msg), .i_first(i_first), .i_last(i_last), .i_mode(i_mode),
    .o_valid(vld[0]), .i_out_ready(i_out_ready), .o_hash(hsh[0]));
  sha2_core #(.UNROLL(2)) u_u2 (
    .usr_clk(usr_clk), .usr_reset(usr_reset), .i_valid(i_valid), .o_ready(rdy[1]),
    .i_msg(i_msg), .i_first(i_first), .i_last(i_last), .i_mode(i_mode),
    .o_valid(vld[1]), .i_out_ready(i_out_ready), .o_hash(hsh[1]));
  sha2_core #(.UNROLL(4)) u_u4 (
    .usr_clk(usr_clk), .usr_reset(usr_reset), .i_valid(i_valid), .o_ready(rdy[2]),
    .i_msg(i_msg), .i_first(i_first), .i_last(i_last), .i_mode(i_mode),
    .o_valid(vld[2]), .i_out_ready(i_out_ready), .o_hash(hsh[2]));

  initial usr_clk = 1'b0;
  always #5 usr_clk = ~usr_clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook single-block compression with a fully expanded 64-word schedule.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  s0, s1, t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  task automatic send_block(input logic [511:0] msg, input logic first, input logic last,
                            input logic mode, input logic [255:0] exp, input string name,
                            input bit hold);
    int lat [3];
    bit early;
    i_valid = 1'b1; i_msg = msg; i_first = first; i_last = last; i_mode = mode;
    @(posedge usr_clk); #1;
    i_valid = 1'b0;
    i_msg = {16{$urandom}}; i_first = 1'($urandom); i_last = 1'($urandom); i_mode = 1'($urandom);
    lat = '{0, 0, 0};
    early = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge usr_clk); #1;
      for (int k = 0; k < 3; k++) begin
        if (lat[k] == 0) begin
          if (last ? vld[k] : rdy[k]) lat[k] = c;
          if (!last && vld[k]) early = 1'b1;
        end
      end
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    for (int k = 0; k < 3; k++)
      check($sformatf("%s latency U%0d", name, 1 << k), lat[k], 64 / (1 << k) + 1);
    if (!last) begin
      check($sformatf("%s no valid mid-message", name), early, 0);
      return;
    end
    for (int k = 0; k < 3; k++)
      check($sformatf("%s digest U%0d", name, 1 << k), hsh[k], exp);
    if (hold) begin
      for (int c = 0; c < 10; c++) begin
        i_valid = 1'($urandom); i_msg = {16{$urandom}}; i_first = 1'b1;
        @(posedge usr_clk); #1;
        for (int k = 0; k < 3; k++) begin
          check($sformatf("%s hold flags U%0d", name, 1 << k), {vld[k], rdy[k]}, 2'b10);
          check($sformatf("%s hold hash U%0d", name, 1 << k), hsh[k], exp);
        end
      end
      i_valid = 1'b0;
    end
    i_out_ready = 1'b1;
    @(posedge usr_clk); #1;
    i_out_ready = 1'b0;
    check($sformatf("%s release {valid,ready}", name),
          {vld[0], vld[1], vld[2], rdy[0], rdy[1], rdy[2]}, 6'b000111);
  endtask

  initial begin
    vec_t         tbl [8];
    logic [255:0] h, exp;
    logic [511:0] blk;
    logic         mode;
    int           nb;

    tbl[0] = '{ABC,   1'b1, 1'b1, 1'b0, D_ABC};
    tbl[1] = '{ABC,   1'b1, 1'b1, 1'b1, D_ABC224};
    tbl[2] = '{EMPTY, 1'b1, 1'b1, 1'b0, D_EMPTY};
    tbl[3] = '{TWO1,  1'b1, 1'b0, 1'b0, 256'h0};
    tbl[4] = '{TWO2,  1'b0, 1'b1, 1'b1, D_TWO};
    tbl[5] = '{TWO1,  1'b1, 1'b0, 1'b0, 256'h0};
    tbl[6] = '{ABC,   1'b1, 1'b1, 1'b0, D_ABC};
    tbl[7] = '{ABC,   1'b0, 1'b1, 1'b1, D_ABC224};

    usr_reset = 1'b1; i_valid = 1'b0; i_out_ready = 1'b0;
    i_msg = '0; i_first = 1'b0; i_last = 1'b0; i_mode = 1'b0;
    repeat (2) @(posedge usr_clk);
    #1 usr_reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset {valid,ready} U%0d", 1 << k), {vld[k], rdy[k]}, 2'b01);
      check($sformatf("reset hash U%0d", 1 << k), hsh[k], 256'h0);
    end

    for (int i = 0; i < 8; i++)
      send_block(tbl[i].msg, tbl[i].first, tbl[i].last, tbl[i].mode, tbl[i].exp,
                 $sformatf("vec%0d", i), i == 0);

    // Abort mid-message: reset lands on the edge where U=1 is at round t=30.
    i_valid = 1'b1; i_msg = ABC; i_first = 1'b1; i_last = 1'b1; i_mode = 1'b0;
    @(posedge usr_clk); #1;
    i_valid = 1'b0;
    repeat (30) @(posedge usr_clk);
    #1 usr_reset = 1'b1; i_valid = 1'b1;
    @(posedge usr_clk); #1;
    usr_reset = 1'b0; i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort {valid,ready} U%0d", 1 << k), {vld[k], rdy[k]}, 2'b01);
      check($sformatf("abort hash U%0d", 1 << k), hsh[k], 256'h0);
    end
    send_block(ABC, 1'b1, 1'b1, 1'b0, D_ABC, "after abort", 1'b0);

    for (int m = 0; m < 4; m++) begin
      mode = 1'($urandom);
      nb   = int'($urandom_range(1, 3));
      h    = mode ? R_IV224 : R_IV256;
      for (int b = 0; b < nb; b++) begin
        blk = {16{$urandom}};
        for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
        h   = compress(h, blk);
        exp = mode ? {h[255:32], 32'h0} : h;
        repeat ($urandom_range(0, 3)) @(posedge usr_clk);
        #1;
        send_block(blk, b == 0, b == nb - 1, (b == 0) ? mode : 1'($urandom), exp,
                   $sformatf("rand%0d blk%0d", m, b), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
